// File: rtl/imul_radix4_seq.sv
// Sequential radix-4 integer multiplier: one two-bit digit of B per clock,
// 0/A/2A/3A partial-product selection into a shift-right accumulator, with
// optional two's-complement operation through magnitude/sign handling.
module imul_radix4_seq #(
  parameter int unsigned SIZE = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              iStart,
  input  logic              iSigned,
  input  logic [SIZE-1:0]   iA,
  input  logic [SIZE-1:0]   iB,
  output logic              oBusy,
  output logic              oDone,
  output logic [2*SIZE-1:0] oResult
);

  localparam int unsigned Digits = SIZE / 2;
  localparam int unsigned CntW   = (Digits > 1) ? $clog2(Digits) : 1;
  localparam int unsigned PpW    = SIZE + 2;
  localparam int unsigned AccW   = 2 * SIZE + 2;
  localparam logic [CntW-1:0] LastCnt = CntW'(Digits - 1);

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e state_q, state_d;

  logic [SIZE-1:0]   mag_a_q;
  logic [PpW-1:0]    a3_q;
  logic [SIZE-1:0]   mag_b_q;
  logic              neg_q;
  logic [AccW-1:0]   acc_q;
  logic [CntW-1:0]   cnt_q;
  logic              done_q;
  logic [2*SIZE-1:0] result_q;

  logic [SIZE-1:0]   mag_a_in;
  logic [SIZE-1:0]   mag_b_in;
  logic [PpW-1:0]    a3_in;
  logic [PpW-1:0]    pp;
  logic [AccW:0]     acc_sum;
  logic [AccW-1:0]   acc_next;
  logic [2*SIZE-1:0] prod;
  logic [2*SIZE-1:0] prod_fixed;

  // Operand magnitudes and 3A, formed from the live inputs for the start edge.
  // Negating -2^(SIZE-1) yields 2^(SIZE-1), which is correct as an unsigned value.
  always_comb begin
    mag_a_in = (iSigned && iA[SIZE-1]) ? -iA : iA;
    mag_b_in = (iSigned && iB[SIZE-1]) ? -iB : iB;
    a3_in    = {2'b00, mag_a_in} + {1'b0, mag_a_in, 1'b0};
  end

  // Partial-product select and accumulate; the digit lands at bit SIZE and the
  // right shift by two moves earlier digits down to their final weight.
  always_comb begin
    pp = '0;
    case (mag_b_q[1:0])
      2'b00:   pp = '0;
      2'b01:   pp = {2'b00, mag_a_q};
      2'b10:   pp = {1'b0, mag_a_q, 1'b0};
      default: pp = a3_q;
    endcase
    acc_sum    = {1'b0, acc_q} + {1'b0, pp, {SIZE{1'b0}}};
    acc_next   = acc_sum[AccW:1] >> 1;
    prod       = acc_q[2*SIZE-1:0];
    prod_fixed = neg_q ? -prod : prod;
  end

  // State register.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; iStart only matters in idle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (iStart) state_d = StRun;
      StRun:   if (cnt_q == LastCnt) state_d = StFix;
      StFix:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs; done and result come straight from registers.
  always_comb begin
    oBusy   = (state_q != StIdle);
    oDone   = done_q;
    oResult = result_q;
  end

  // Datapath registers: operand capture, digit iteration and result write.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      mag_a_q  <= '0;
      a3_q     <= '0;
      mag_b_q  <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (iStart) begin
            mag_a_q <= mag_a_in;
            a3_q    <= a3_in;
            mag_b_q <= mag_b_in;
            neg_q   <= iSigned & (iA[SIZE-1] ^ iB[SIZE-1]);
            acc_q   <= '0;
            cnt_q   <= '0;
          end
        end
        StRun: begin
          acc_q   <= acc_next;
          mag_b_q <= mag_b_q >> 2;
          cnt_q   <= cnt_q + CntW'(1);
        end
        StFix: begin
          result_q <= prod_fixed;
          done_q   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/imul_radix4_seq.md
# imul_radix4_seq

Sequential, parameterised integer multiplier that retires one radix-4 digit (two multiplier bits) of B per clock. It uses a 0/A/2A/3A partial-product selection plus accumulate. It extends our combinational 4-bit multiplier family to arbitrary even widths, adds optional two's-complement operation, and adds a start/done handshake. It sits beside the ALU as a multi-cycle execution unit: the control FSM issues a start and waits for done.

## Interface
- SIZE, 4: operand width in bits; must be even and ≥ 4.
- Clock  in  1  single clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- iStart  in  1  request; sampled only while idle.
- iSigned  in  1  1 = operands and result are two's complement, 0 = unsigned; sampled with iStart.
- iA  in  SIZE  multiplicand; sampled with iStart.
- iB  in  SIZE  multiplier; sampled with iStart.
- oBusy  out  1  high while a multiplication is in progress.
- oDone  out  1  one-cycle pulse when oResult is updated.
- oResult  out  2*SIZE  product; holds its value until the next completion.

## Operation
- States:
  - IDLE: waiting for a request.
  - RUN: SIZE/2 iterations.
  - FIX: sign correction and result write.
- IDLE → RUN on a rising edge with iStart=1. On that edge the block latches:
  - magA = |iA| and magB = |iB| (two's-complement magnitude when iSigned=1, raw value otherwise), each SIZE bits unsigned;
  - neg = iSigned & (iA[SIZE-1] ^ iB[SIZE-1]);
  - the accumulator is cleared and the digit counter is set to 0.
- Magnitude of the most-negative input −2^(SIZE-1) is 2^(SIZE-1). This fits in SIZE unsigned bits and needs no special case.
- Each RUN edge i (i = 0 … SIZE/2−1):
  - digit d = magB[2i+1:2i];
  - partial product = 0, magA, magA<<1 or (magA<<1)+magA for d = 00/01/10/11, SIZE+2 bits wide;
  - the partial product is added to the accumulator at weight 4^i. Use a shift-right accumulator of 2*SIZE+2 bits; carries are never lost.
- After the last digit, RUN → FIX. FIX → IDLE.
- On the FIX edge:
  - oResult ← neg ? −P : P, where P is the 2*SIZE-bit unsigned product;
  - oDone ← 1.
- The full signed product always fits in 2*SIZE bits, so there is no overflow flag.
- iStart in RUN or FIX is ignored. It is not queued.
- The cycle in which oDone=1 is already in IDLE, so a new iStart in that cycle is accepted (back-to-back issue).
- oBusy = 1 exactly in RUN and FIX.
- Reset (asynchronous, any time including mid-run):
  - state ← IDLE;
  - oBusy, oDone ← 0;
  - oResult ← 0;
  - accumulator and counter ← 0.
  - No partial result is ever written after reset.

## Timing
- Let N be the edge that samples iStart=1 in IDLE.
- oBusy rises after edge N and falls after edge N+SIZE/2+1.
- oDone is high for exactly the one cycle following edge N+SIZE/2+1; oResult is valid from that same cycle.
- Latency is SIZE/2+1 edges; SIZE=4 gives 3, SIZE=8 gives 5.
- Maximum throughput is one product per SIZE/2+1 cycles.
- Operand inputs may change freely after edge N.
- oResult is registered, with no combinational path from any input.
- Critical path: one SIZE+2-bit 3A generation (shift+add) feeding one 2*SIZE+2-bit add. 3A may be precomputed at start to shorten it.

## Test plan
- Reset: hold Reset=0, then release. Required: oBusy=0, oDone=0, oResult=0. iStart while Reset=0 has no effect.
- SIZE=4 unsigned: iA=15, iB=15, iStart at edge N. Required:
  - oBusy high for 3 cycles;
  - oDone pulses after edge N+3;
  - oResult=8'hE1 (225) and is held afterwards.
- SIZE=4 signed:
  - −3×5 → 8'hF1;
  - −8×−8 → 8'h40;
  - −8×7 → 8'hC8;
  - 0×−1 → 8'h00 (no negative zero issue).
  - Unsigned 8×8 with the same bits → 8'h40.
- Handshake:
  - iStart pulses and operand changes during RUN/FIX are ignored; the result matches the first operands.
  - iStart asserted in the oDone cycle starts a second operation immediately; its oDone comes 3 edges later.
- Reset mid-run: assert Reset at RUN iteration 1 of 7×9. Required:
  - outputs clear asynchronously;
  - no oDone appears;
  - the previous oResult is not retained (reads 0);
  - the next request computes correctly.
- SIZE=8: 255×255 unsigned → 16'hFE01 with latency 5. Also run 1000 random operand/mode pairs checked against a behavioural `*` model for SIZE=4, 8 and 16.
